pc_fetch_stage: RTL

Instruction-fetch stage of the pipelined datapath. Holds the program counter, drives the instruction-memory address, and registers fetched words into the IF/ID pipeline register. Publishes the fetched PC for the branch-target adder (PC + sign-extended offset) and consumes that adder's 32-bit sum as the redirect target. Handles hazard stalls, branch/jump flush, halt, and two saturating fetch statistics counters.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/sat_counter.sv | 32 +++
 rtl/pc_fetch_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Imported by pc_fetch_stage and sat_counter.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP  = 32'd1;
    localparam int          DEF_CNT_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter
    import fetch_pkg::*;
#(
    parameter int W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, BOOT/RUN/HALTED FSM
// and saturating fetch/redirect statistics.
module pc_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEF_PC_STEP,
    parameter int          CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_target,
    input  logic             halt_req,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  ifid_pc_q;
    logic [31:0]  ifid_instr_q;
    logic         ifid_valid_q;
    logic         halted_q;

    logic run;
    logic take_halt;
    logic take_redir;
    logic take_fetch;

    // Halt outranks redirect, which outranks stall.
    assign run        = (state_q == RUN);
    assign take_halt  = run & halt_req;
    assign take_redir = run & ~halt_req & redirect;
    assign take_fetch = run & ~halt_req & ~redirect & ~stall;

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            take_redir: pc_d = redirect_target;
            take_fetch: pc_d = pc_q + PC_STEP;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (take_halt) begin
                        state_q      <= HALTED;
                        halted_q     <= 1'b1;
                        ifid_valid_q <= 1'b0;
                    end else if (take_redir) begin
                        ifid_valid_q <= 1'b0;
                    end else if (take_fetch) begin
                        ifid_pc_q    <= pc_q;
                        ifid_instr_q <= imem_rdata;
                        ifid_valid_q <= 1'b1;
                    end
                end
                HALTED: ifid_valid_q <= 1'b0;
                default: state_q <= BOOT;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (take_fetch),
        .cnt_o (fetch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (take_redir),
        .cnt_o (redirect_cnt)
    );

    assign imem_addr  = pc_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;
    assign halted     = halted_q;

endmodule
